// File: rtl/uart_rgb_cmd_pkg.sv
// uart_rgb_cmd_pkg: shared parser states, ASCII constants, channel indices and hex decode
package uart_rgb_cmd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_TERM, S_ERR} state_e;
  typedef struct packed {
    logic       vld;
    logic [3:0] val;
  } nib_t;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_Q  = 8'h3F;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_G  = 8'h47;
  localparam logic [7:0] ASCII_B  = 8'h42;
  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;
  // Letters are folded to lower case so 'A'-'F' and 'a'-'f' share one range test.
  function automatic nib_t hex_nib(input logic [7:0] c);
    nib_t n;
    logic [7:0] l;
    l = c | 8'h20;
    n.vld = 1'b1;
    n.val = c[3:0];
    if (l >= 8'h61 && l <= 8'h66) n.val = c[3:0] + 4'd9;
    else if (!(c >= 8'h30 && c <= 8'h39)) begin
      n.vld = 1'b0;
      n.val = 4'd0;
    end
    return n;
  endfunction
endpackage

// File: rtl/uart_rgb_cmd_if.sv
// uart_rgb_cmd_if: byte stream from the UART receiver and response byte to the transmitter
// rx_data/rx_valid: received byte strobe; tx_data/tx_valid/tx_ready: response handshake
interface uart_rgb_cmd_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
  modport slave (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/rgb_pwm.sv
// rgb_pwm: prescaled 8-bit PWM for three channels with period-aligned duty shadows
// hw_clk/resetn: clock, sync active-low reset; duty_r/g/b: committed duties; rgbN_pwm: registered outputs
module rgb_pwm #(
  parameter int unsigned PWM_DIV = 16
) (
  input  logic       hw_clk,
  input  logic       resetn,
  input  logic [7:0] duty_r,
  input  logic [7:0] duty_g,
  input  logic [7:0] duty_b,
  output logic       rgb0_pwm,
  output logic       rgb1_pwm,
  output logic       rgb2_pwm
);
  logic [15:0]      pre_q, pre_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [2:0][7:0]  shd_q, shd_d;
  logic [2:0]       pwm_q, pwm_d;
  logic             step;
  // Shadows reload on the same edge pwm_cnt wraps to 0, so a period never mixes duties.
  always_comb begin
    step  = pre_q == 16'(PWM_DIV - 1);
    pre_d = step ? 16'd0 : pre_q + 16'd1;
    cnt_d = cnt_q + 8'(step);
    shd_d = (step && cnt_q == 8'hFF) ? {duty_b, duty_g, duty_r} : shd_q;
    for (int i = 0; i < 3; i++) pwm_d[i] = cnt_q < shd_q[i];
  end
  always_ff @(posedge hw_clk) begin
    if (!resetn) begin
      pre_q <= '0;
      cnt_q <= '0;
      shd_q <= '0;
      pwm_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      shd_q <= shd_d;
      pwm_q <= pwm_d;
    end
  end
  assign rgb0_pwm = pwm_q[0];
  assign rgb1_pwm = pwm_q[1];
  assign rgb2_pwm = pwm_q[2];
endmodule

// File: rtl/uart_rgb_cmd.sv
// uart_rgb_cmd: ASCII "R1F<CR>" command parser driving three RGB PWM channels
// hw_clk/resetn: clock, sync active-low reset; bus: rx byte strobe and tx response (slave side)
// rgb0/1/2_pwm: R/G/B PWM; duty_r/g/b: committed duties; overrun: sticky dropped response
// UART_RGB_CMD_ECHO_EN: when defined, K/? responses are returned on bus.tx_*; otherwise tx and overrun read 0
module uart_rgb_cmd
  import uart_rgb_cmd_pkg::*;
#(
  parameter int unsigned PWM_DIV = 16
) (
  input  logic                 hw_clk,
  input  logic                 resetn,
  uart_rgb_cmd_if.slave        bus,
  output logic                 rgb0_pwm,
  output logic                 rgb1_pwm,
  output logic                 rgb2_pwm,
  output logic [7:0]           duty_r,
  output logic [7:0]           duty_g,
  output logic [7:0]           duty_b,
  output logic                 overrun
);
  state_e          state_q, state_d;
  logic [1:0]      ch_q, ch_d, ch_in;
  logic [7:0]      val_q, val_d, up;
  logic [2:0][7:0] duty_q, duty_d;
  logic            is_term, is_ch, resp_due;
  logic [7:0]      resp_byte;
  nib_t            nib;
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    val_d     = val_q;
    duty_d    = duty_q;
    resp_due  = 1'b0;
    resp_byte = ASCII_Q;
    up        = bus.rx_data & 8'hDF;
    is_term   = bus.rx_data == ASCII_CR || bus.rx_data == ASCII_LF;
    is_ch     = up == ASCII_R || up == ASCII_G || up == ASCII_B;
    ch_in     = up == ASCII_R ? CH_R : up == ASCII_G ? CH_G : CH_B;
    nib       = hex_nib(bus.rx_data);
    if (bus.rx_valid) begin
      case (state_q)
        S_IDLE: begin
          state_d = is_term ? S_IDLE : is_ch ? S_HI : S_ERR;
          ch_d    = is_ch ? ch_in : ch_q;
        end
        S_HI: begin
          state_d    = is_term ? S_IDLE : nib.vld ? S_LO : S_ERR;
          val_d[7:4] = nib.vld ? nib.val : val_q[7:4];
          resp_due   = is_term;
        end
        S_LO: begin
          state_d    = is_term ? S_IDLE : nib.vld ? S_TERM : S_ERR;
          val_d[3:0] = nib.vld ? nib.val : val_q[3:0];
          resp_due   = is_term;
        end
        S_TERM: begin
          state_d   = is_term ? S_IDLE : S_ERR;
          resp_due  = is_term;
          resp_byte = ASCII_K;
          for (int i = 0; i < 3; i++) if (is_term && ch_q == 2'(i)) duty_d[i] = val_q;
        end
        S_ERR: begin
          state_d  = is_term ? S_IDLE : S_ERR;
          resp_due = is_term;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge hw_clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ch_q    <= CH_R;
      val_q   <= '0;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      val_q   <= val_d;
      duty_q  <= duty_d;
    end
  end
  assign duty_r = duty_q[CH_R];
  assign duty_g = duty_q[CH_G];
  assign duty_b = duty_q[CH_B];
`ifdef UART_RGB_CMD_ECHO_EN
  logic       tx_valid_q, tx_valid_d, overrun_q, overrun_d;
  logic [7:0] tx_data_q, tx_data_d;
  // A handshake frees the slot on the same edge a new response may load into it.
  always_comb begin
    tx_valid_d = tx_valid_q & ~bus.tx_ready;
    tx_data_d  = tx_data_q;
    overrun_d  = overrun_q;
    if (resp_due) begin
      if (tx_valid_q && !bus.tx_ready) overrun_d = 1'b1;
      else begin
        tx_valid_d = 1'b1;
        tx_data_d  = resp_byte;
      end
    end
  end
  always_ff @(posedge hw_clk) begin
    if (!resetn) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      overrun_q  <= 1'b0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      overrun_q  <= overrun_d;
    end
  end
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign overrun      = overrun_q;
`else
  logic unused_resp;
  assign unused_resp  = ^{bus.tx_ready, resp_due, resp_byte};
  assign bus.tx_valid = 1'b0;
  assign bus.tx_data  = 8'h00;
  assign overrun      = 1'b0;
`endif
  rgb_pwm #(.PWM_DIV(PWM_DIV)) u_pwm (
    .hw_clk   (hw_clk),
    .resetn   (resetn),
    .duty_r   (duty_r),
    .duty_g   (duty_g),
    .duty_b   (duty_b),
    .rgb0_pwm (rgb0_pwm),
    .rgb1_pwm (rgb1_pwm),
    .rgb2_pwm (rgb2_pwm)
  );
endmodule

// File: tb/tb_uart_rgb_cmd.sv
// tb_uart_rgb_cmd: scoreboard bench for the command parser, response path and PWM outputs
module tb_uart_rgb_cmd;
  import uart_rgb_cmd_pkg::*;
  localparam int DIV = 2;
  localparam int PER = 256 * DIV;
`ifdef UART_RGB_CMD_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif
  logic       hw_clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rgb0_pwm, rgb1_pwm, rgb2_pwm, overrun;
  logic [7:0] duty_r, duty_g, duty_b;
  int         n_vec = 0;
  int         n_err = 0;
  int         hr, hg, hb;
  typedef struct {
    logic [7:0] resp;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } exp_t;
  exp_t sb[$];
  uart_rgb_cmd_if bus ();
  uart_rgb_cmd #(.PWM_DIV(DIV)) dut (
    .hw_clk   (hw_clk),
    .resetn   (resetn),
    .bus      (bus),
    .rgb0_pwm (rgb0_pwm),
    .rgb1_pwm (rgb1_pwm),
    .rgb2_pwm (rgb2_pwm),
    .duty_r   (duty_r),
    .duty_g   (duty_g),
    .duty_b   (duty_b),
    .overrun  (overrun)
  );
  always #5 hw_clk = ~hw_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic put(input logic [7:0] b);
    @(negedge hw_clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge hw_clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    chk("duty_r", duty_r, e.r);
    chk("duty_g", duty_g, e.g);
    chk("duty_b", duty_b, e.b);
    chk("tx_valid", bus.tx_valid, ECHO);
    chk("tx_data", bus.tx_data, ECHO ? e.resp : 8'h00);
  endtask
  task automatic cmd(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                     input logic [7:0] b3, input logic [7:0] resp, input logic [7:0] r,
                     input logic [7:0] g, input logic [7:0] b);
    logic [7:0] bs [4];
    exp_t e;
    bs = '{b0, b1, b2, b3};
    e  = '{resp, r, g, b};
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) sb.push_back(e);
      put(bs[i]);
    end
    pop_check();
  endtask
  task automatic measure(output int r, output int g, output int b);
    r = 0;
    g = 0;
    b = 0;
    repeat (PER) begin
      @(negedge hw_clk);
      r += int'(rgb0_pwm);
      g += int'(rgb1_pwm);
      b += int'(rgb2_pwm);
    end
  endtask
  task automatic wait_rise();
    logic prev, seen;
    prev = rgb0_pwm;
    seen = 1'b0;
    for (int i = 0; i < 3 * PER && !seen; i++) begin
      @(negedge hw_clk);
      seen = rgb0_pwm && !prev;
      prev = rgb0_pwm;
    end
    chk("rgb0_rise", seen, 1'b1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) @(negedge hw_clk);
    resetn = 1'b1;
    chk("rst_duty_r", duty_r, 8'h00);
    chk("rst_duty_g", duty_g, 8'h00);
    chk("rst_duty_b", duty_b, 8'h00);
    chk("rst_tx_valid", bus.tx_valid, 1'b0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_pwm", {rgb2_pwm, rgb1_pwm, rgb0_pwm}, 3'b000);
    cmd(4, "R", "8", "0", ASCII_CR, ASCII_K, 8'h80, 8'h00, 8'h00);
    @(negedge hw_clk);
    chk("tx_handshake", bus.tx_valid, 1'b0);
    put(ASCII_LF);
    chk("lf_quiet", bus.tx_valid, 1'b0);
    chk("lf_duty_r", duty_r, 8'h80);
    repeat (PER + 4) @(negedge hw_clk);
    measure(hr, hg, hb);
    chk("r80_high", hr, 128 * DIV);
    chk("g0_high", hg, 0);
    chk("b0_high", hb, 0);
    cmd(4, "g", "f", "F", ASCII_LF, ASCII_K, 8'h80, 8'hFF, 8'h00);
    cmd(4, "b", "0", "0", ASCII_CR, ASCII_K, 8'h80, 8'hFF, 8'h00);
    repeat (PER + 4) @(negedge hw_clk);
    measure(hr, hg, hb);
    chk("r80_high2", hr, 128 * DIV);
    chk("gff_high", hg, PER - DIV);
    chk("b00_high", hb, 0);
    cmd(4, "R", "X", "1", ASCII_CR, ASCII_Q, 8'h80, 8'hFF, 8'h00);
    cmd(4, "R", "1", "0", ASCII_CR, ASCII_K, 8'h10, 8'hFF, 8'h00);
    cmd(2, "r", ASCII_CR, 8'h00, 8'h00, ASCII_Q, 8'h10, 8'hFF, 8'h00);
    cmd(3, "G", "4", ASCII_LF, 8'h00, ASCII_Q, 8'h10, 8'hFF, 8'h00);
    bus.tx_ready = 1'b0;
    cmd(4, "G", "3", "3", ASCII_CR, ASCII_K, 8'h10, 8'h33, 8'h00);
    chk("no_overrun_yet", overrun, 1'b0);
    cmd(4, "B", "9", "a", ASCII_CR, ASCII_K, 8'h10, 8'h33, 8'h9A);
    chk("overrun_set", overrun, ECHO);
    bus.tx_ready = 1'b1;
    @(negedge hw_clk);
    chk("tx_released", bus.tx_valid, 1'b0);
    chk("overrun_sticky", overrun, ECHO);
    cmd(4, "R", "8", "0", ASCII_CR, ASCII_K, 8'h80, 8'h33, 8'h9A);
    repeat (PER + 4) @(negedge hw_clk);
    wait_rise();
    repeat (40 * DIV) @(negedge hw_clk);
    cmd(4, "R", "4", "0", ASCII_CR, ASCII_K, 8'h40, 8'h33, 8'h9A);
    repeat (50 * DIV) @(negedge hw_clk);
    chk("r_old_duty_held", rgb0_pwm, 1'b1);
    wait_rise();
    measure(hr, hg, hb);
    chk("r40_high", hr, 8'h40 * DIV);
    chk("g33_high", hg, 8'h33 * DIV);
    chk("b9a_high", hb, 8'h9A * DIV);
    put("B");
    put("5");
    resetn = 1'b0;
    repeat (2) @(negedge hw_clk);
    resetn = 1'b1;
    chk("rst2_duty_r", duty_r, 8'h00);
    chk("rst2_duty_g", duty_g, 8'h00);
    chk("rst2_duty_b", duty_b, 8'h00);
    chk("rst2_pwm", {rgb2_pwm, rgb1_pwm, rgb0_pwm}, 3'b000);
    chk("rst2_tx_valid", bus.tx_valid, 1'b0);
    chk("rst2_overrun", overrun, 1'b0);
    cmd(2, "5", ASCII_CR, 8'h00, 8'h00, ASCII_Q, 8'h00, 8'h00, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
